// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer event collector: default sizes and the
// index-width helper used for the channel select and hit ports.
package timer_irq_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 4;

  // A single channel still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_irq_if.sv
// Bus between the event sources/software side and the timer_irq collector.
interface timer_irq_if
  import timer_irq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
);

  localparam int IW = idx_w(N);

  logic [N-1:0]  ev;
  logic          mask_put;
  logic [N-1:0]  mask_value;
  logic          ack_put;
  logic [N-1:0]  ack_value;
  logic [IW-1:0] sel;
  logic [N-1:0]  pending;
  logic          irq;
  logic [IW-1:0] hit;
  logic [CW-1:0] miss;

  modport master (
    output ev, mask_put, mask_value, ack_put, ack_value, sel,
    input  pending, irq, hit, miss
  );

  modport slave (
    input  ev, mask_put, mask_value, ack_put, ack_value, sel,
    output pending, irq, hit, miss
  );

endinterface

// File: rtl/timer_irq_prio_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any flag.
module timer_irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Sticky, maskable event flags with a combined registered interrupt, lowest
// active source report and per-channel saturating lost-event counters.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic        clock,
  input  logic        reset,
  timer_irq_if.slave  bus
);

  localparam int IW = idx_w(N);

  logic [N-1:0]    ev_p0;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    pending_p1;
  logic [N-1:0]    mask_p1;
  logic [N-1:0]    active;
  logic            irq_p2;
  logic [IW-1:0]   hit_p2;
  logic [IW-1:0]   hit_enc;
  logic            hit_any;
  logic [N*CW-1:0] miss_flat;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Stage 0: edge detect against the previous sample of ev. The sample also
  // loads during reset so lines held high through reset give no edge.
  always_ff @(posedge clock) begin
    ev_p0 <= bus.ev;
  end

  always_comb begin
    rise   = bus.ev & ~ev_p0;
    clr    = bus.ack_put ? bus.ack_value : '0;
    active = pending_p1 & mask_p1;
  end

  // Stage 1: sticky flags (a new edge beats a same-cycle ack) and mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_p1 <= '0;
      mask_p1    <= '0;
    end else begin
      pending_p1 <= (pending_p1 & ~clr) | rise;
      if (bus.mask_put) mask_p1 <= bus.mask_value;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_miss
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if (clr[g]) begin
        cnt <= '0;
      end else if (rise[g] && pending_p1[g]) begin
        cnt <= sat_inc(cnt);
      end
    end

    assign miss_flat[g*CW +: CW] = cnt;
  end

  timer_irq_prio_enc #(
    .N  (N),
    .IW (IW)
  ) u_prio (
    .vec (active),
    .idx (hit_enc),
    .any (hit_any)
  );

  // Stage 2: registered request; hit keeps the last winner while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_p2 <= 1'b0;
      hit_p2 <= '0;
    end else begin
      irq_p2 <= hit_any;
      if (hit_any) hit_p2 <= hit_enc;
    end
  end

  // Unmatched select codes (sel >= N) fall through to zero.
  always_comb begin
    bus.miss = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == IW'(i)) bus.miss = miss_flat[i*CW +: CW];
    end
  end

  assign bus.pending = pending_p1;
  assign bus.irq     = irq_p2;
  assign bus.hit     = hit_p2;

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed scenarios plus a randomized run against an
// abstract per-channel reference model.
module tb_timer_irq;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MAXM = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;

  timer_irq_if #(.N(N), .CW(CW)) bus();

  timer_irq #(.N(N), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_pend[N];
  bit m_mask[N];
  bit m_prev[N];
  int m_miss[N];
  bit m_irq;
  int m_hit;

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    bit any;
    int low;
    bit e;
    bit a;
    any = 0;
    low = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i] && m_mask[i]) begin
        any = 1;
        low = i;
      end
    end
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_mask[i] = 0;
        m_miss[i] = 0;
        m_prev[i] = bus.ev[i];
      end
      m_irq = 0;
      m_hit = 0;
      return;
    end
    m_irq = any;
    if (any) m_hit = low;
    for (int i = 0; i < N; i++) begin
      e = bus.ev[i] && !m_prev[i];
      a = bus.ack_put && bus.ack_value[i];
      if (a) m_miss[i] = 0;
      else if (e && m_pend[i]) m_miss[i] = (m_miss[i] + 1 > MAXM) ? MAXM : m_miss[i] + 1;
      if (e) m_pend[i] = 1;
      else if (a) m_pend[i] = 0;
      if (bus.mask_put) m_mask[i] = bus.mask_value[i];
      m_prev[i] = bus.ev[i];
    end
  endtask

  function automatic logic [N-1:0] m_pvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ev = 4'b1111;
    bus.mask_put = 1'b0;
    bus.mask_value = '0;
    bus.ack_put = 1'b0;
    bus.ack_value = '0;
    bus.sel = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL reset_pending: got %b expected %b", bus.pending, 4'b0000); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    n_cmp++;
    if (bus.hit !== 2'd0) begin n_bad++; $display("FAIL reset_hit: got %0d expected 0", bus.hit); end
    n_cmp++;
    for (int s = 0; s < N; s++) begin
      bus.sel = 2'(s);
      #1;
      if (bus.miss !== 4'd0) begin n_bad++; $display("FAIL reset_miss%0d: got %0d expected 0", s, bus.miss); end
      n_cmp++;
    end
    bus.ev = '0;
    tick();
  endtask

  task automatic test_single();
    bus.mask_put = 1'b1;
    bus.mask_value = 4'b0101;
    tick();
    bus.mask_put = 1'b0;
    bus.ev = 4'b0100;
    tick();
    bus.ev = '0;
    if (bus.pending !== 4'b0100) begin n_bad++; $display("FAIL single_pending: got %b expected %b", bus.pending, 4'b0100); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_early: got %b expected 0", bus.irq); end
    n_cmp++;
    tick();
    if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL single_irq: got %b expected 1", bus.irq); end
    n_cmp++;
    if (bus.hit !== 2'd2) begin n_bad++; $display("FAIL single_hit: got %0d expected 2", bus.hit); end
    n_cmp++;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b1111;
    tick();
    bus.ack_put = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    bus.mask_put = 1'b1;
    bus.mask_value = 4'b1010;
    tick();
    bus.mask_put = 1'b0;
    bus.ev = 4'b1010;
    tick();
    bus.ev = '0;
    tick();
    if (bus.pending !== 4'b1010) begin n_bad++; $display("FAIL simul_pending: got %b expected %b", bus.pending, 4'b1010); end
    n_cmp++;
    if (bus.hit !== 2'd1) begin n_bad++; $display("FAIL simul_hit_low: got %0d expected 1", bus.hit); end
    n_cmp++;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b0010;
    tick();
    bus.ack_put = 1'b0;
    tick();
    if (bus.hit !== 2'd3) begin n_bad++; $display("FAIL simul_hit_next: got %0d expected 3", bus.hit); end
    n_cmp++;
    if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL simul_irq_stays: got %b expected 1", bus.irq); end
    n_cmp++;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b1000;
    tick();
    bus.ack_put = 1'b0;
    if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL simul_irq_k1: got %b expected 1", bus.irq); end
    n_cmp++;
    tick();
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL simul_irq_drop: got %b expected 0", bus.irq); end
    n_cmp++;
    if (bus.hit !== 2'd3) begin n_bad++; $display("FAIL simul_hit_hold: got %0d expected 3", bus.hit); end
    n_cmp++;
  endtask

  task automatic test_saturate();
    bus.sel = 2'd0;
    for (int p = 0; p < 20; p++) begin
      bus.ev = 4'b0001;
      tick();
      bus.ev = '0;
      tick();
    end
    if (bus.pending[0] !== 1'b1) begin n_bad++; $display("FAIL sat_pending: got %b expected 1", bus.pending[0]); end
    n_cmp++;
    if (bus.miss !== 4'd15) begin n_bad++; $display("FAIL sat_miss: got %0d expected 15", bus.miss); end
    n_cmp++;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b0001;
    tick();
    bus.ack_put = 1'b0;
    if (bus.miss !== 4'd0) begin n_bad++; $display("FAIL sat_miss_ack: got %0d expected 0", bus.miss); end
    n_cmp++;
    if (bus.pending[0] !== 1'b0) begin n_bad++; $display("FAIL sat_pending_ack: got %b expected 0", bus.pending[0]); end
    n_cmp++;
    tick();
  endtask

  task automatic test_ack_edge();
    bus.sel = 2'd0;
    for (int p = 0; p < 2; p++) begin
      bus.ev = 4'b0001;
      tick();
      bus.ev = '0;
      tick();
    end
    if (bus.miss !== 4'd1) begin n_bad++; $display("FAIL ackedge_miss_pre: got %0d expected 1", bus.miss); end
    n_cmp++;
    bus.ev = 4'b0001;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b0001;
    tick();
    bus.ev = '0;
    bus.ack_put = 1'b0;
    if (bus.pending[0] !== 1'b1) begin n_bad++; $display("FAIL ackedge_pending: got %b expected 1", bus.pending[0]); end
    n_cmp++;
    if (bus.miss !== 4'd0) begin n_bad++; $display("FAIL ackedge_miss: got %0d expected 0", bus.miss); end
    n_cmp++;
    bus.ack_put = 1'b1;
    bus.ack_value = 4'b1111;
    tick();
    bus.ack_put = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_unmask_reset();
    bus.mask_put = 1'b1;
    bus.mask_value = 4'b0000;
    tick();
    bus.mask_put = 1'b0;
    bus.ev = 4'b0001;
    tick();
    bus.ev = '0;
    tick();
    tick();
    if (bus.pending !== 4'b0001) begin n_bad++; $display("FAIL unmask_pending: got %b expected %b", bus.pending, 4'b0001); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL unmask_irq_masked: got %b expected 0", bus.irq); end
    n_cmp++;
    bus.mask_put = 1'b1;
    bus.mask_value = 4'b0001;
    tick();
    bus.mask_put = 1'b0;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL unmask_irq_load: got %b expected 0", bus.irq); end
    n_cmp++;
    tick();
    if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL unmask_irq: got %b expected 1", bus.irq); end
    n_cmp++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL midreset_pending: got %b expected %b", bus.pending, 4'b0000); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %b expected 0", bus.irq); end
    n_cmp++;
    tick();
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq_after: got %b expected 0", bus.irq); end
    n_cmp++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.ev = 4'($urandom_range(0, 15));
      bus.mask_put = ($urandom_range(0, 7) == 0);
      bus.mask_value = 4'($urandom_range(0, 15));
      bus.ack_put = ($urandom_range(0, 3) == 0);
      bus.ack_value = 4'($urandom_range(0, 15));
      bus.sel = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 63) == 0);
      tick();
      if (bus.pending !== m_pvec()) begin n_bad++; $display("FAIL rand_pending c=%0d: got %b expected %b", c, bus.pending, m_pvec()); end
      n_cmp++;
      if (bus.irq !== m_irq) begin n_bad++; $display("FAIL rand_irq c=%0d: got %b expected %b", c, bus.irq, m_irq); end
      n_cmp++;
      if (bus.hit !== 2'(m_hit)) begin n_bad++; $display("FAIL rand_hit c=%0d: got %0d expected %0d", c, bus.hit, m_hit); end
      n_cmp++;
      if (bus.miss !== 4'(m_miss[bus.sel])) begin n_bad++; $display("FAIL rand_miss c=%0d sel=%0d: got %0d expected %0d", c, bus.sel, bus.miss, m_miss[bus.sel]); end
      n_cmp++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_saturate();
    test_ack_edge();
    test_unmask_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
